// File: rtl/gem_cluster_rom_sched_if.sv
// gem_cluster_rom_sched_if
// Bundles the frame-input and translator-output signals of the GEM cluster
// ROM scheduler.
//   slave  : scheduler side (receives frames, drives issue/result/status)
//   master : the environment side (cluster receiver, translator, matcher)
// Signals:
//   frame_start, clusters_in[NCL*14], vpf_in[NCL], ovf_clear   -> scheduler
//   iss_cluster[14], iss_vpf, iss_roll, iss_pad, iss_size,
//   iss_idx, res_valid, res_idx, frame_done, busy, overflow    <- scheduler
interface gem_cluster_rom_sched_if #(
  parameter int NCL  = 8,
  parameter int IDXB = 3
);
  logic                frame_start;
  logic [NCL*14-1:0]   clusters_in;
  logic [NCL-1:0]      vpf_in;
  logic                ovf_clear;

  logic [13:0]         iss_cluster;
  logic                iss_vpf;
  logic [2:0]          iss_roll;
  logic [7:0]          iss_pad;
  logic [2:0]          iss_size;
  logic [IDXB-1:0]     iss_idx;
  logic                res_valid;
  logic [IDXB-1:0]     res_idx;
  logic                frame_done;
  logic                busy;
  logic                overflow;

  modport slave (
    input  frame_start, clusters_in, vpf_in, ovf_clear,
    output iss_cluster, iss_vpf, iss_roll, iss_pad, iss_size, iss_idx,
           res_valid, res_idx, frame_done, busy, overflow
  );

  modport master (
    output frame_start, clusters_in, vpf_in, ovf_clear,
    input  iss_cluster, iss_vpf, iss_roll, iss_pad, iss_size, iss_idx,
           res_valid, res_idx, frame_done, busy, overflow
  );
endinterface

// File: rtl/gem_cluster_rom_sched.sv
// gem_cluster_rom_sched
// Time-multiplexes a frame of up to NCL GEM clusters, one per clock, into a
// single cluster_to_cscwirehalfstrip_rom translator (one-cycle latency).
// A frame is latched on frame_start, pending slots are issued lowest index
// first, res_valid/res_idx tag the translator output one cycle later, and
// frame_done pulses in the DRAIN cycle together with the last result.
// Ports:
//   clock  : fabric clock
//   reset  : asynchronous, active-high
//   bus    : gem_cluster_rom_sched_if.slave (frame inputs, issue/result/status)
// Build option:
//   GEM_SCHED_SKIP_INVALID_EN - when defined, only slots with vpf_in set are
//   issued (variable latency); otherwise every slot is issued (fixed latency).
module gem_cluster_rom_sched #(
  parameter int NCL  = 8,
  parameter int IDXB = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  gem_cluster_rom_sched_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [NCL-1:0]  pend_q, pend_d;
  logic [NCL-1:0]  v_q;
  logic [13:0]     data_q [NCL];
  logic            res_valid_q;
  logic [IDXB-1:0] res_idx_q;
  logic            overflow_q, overflow_d;

  logic            accept;
  logic            drop;
  logic            issue;
  logic            found;
  logic [IDXB-1:0] p;
  logic [NCL-1:0]  p_onehot;
  logic [NCL-1:0]  pend_load;
  logic [13:0]     iss_cluster_w;
  logic [IDXB-1:0] iss_idx_w;

`ifdef GEM_SCHED_SKIP_INVALID_EN
  assign pend_load = bus.vpf_in;
`else
  assign pend_load = '1;
`endif

  // Lowest set bit of pend: scan downward so the last hit is the lowest.
  always_comb begin : pick_lowest
    found = 1'b0;
    p     = '0;
    for (int i = NCL - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        found = 1'b1;
        p     = IDXB'(i);
      end
    end
  end

  assign p_onehot = found ? ({{(NCL-1){1'b0}}, 1'b1} << p) : '0;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin : next_state
    state_d = state_q;
    pend_d  = pend_q;
    accept  = 1'b0;
    drop    = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_start) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A frame arriving while issuing cannot be held; it is dropped.
        drop   = bus.frame_start;
        issue  = found;
        pend_d = pend_q & ~p_onehot;
        if (pend_d == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.frame_start) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) pend_d = pend_load;
  end

  // A drop coinciding with ovf_clear must leave the flag set.
  assign overflow_d = drop ? 1'b1 : (bus.ovf_clear ? 1'b0 : overflow_q);

  assign iss_cluster_w = issue ? data_q[p] : 14'd0;
  assign iss_idx_w     = issue ? p : '0;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      res_valid_q <= issue;
      res_idx_q   <= iss_idx_w;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the frame store is reset as well, so an abandoned frame can never
  // leak stale cluster data into a later issue cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < NCL; i++) data_q[i] <= 14'd0;
    end else if (accept) begin
      v_q <= bus.vpf_in;
      for (int i = 0; i < NCL; i++) data_q[i] <= bus.clusters_in[14*i +: 14];
    end
  end

  assign bus.iss_cluster = iss_cluster_w;
  assign bus.iss_vpf     = issue & v_q[p];
  assign bus.iss_size    = iss_cluster_w[13:11];
  assign bus.iss_roll    = iss_cluster_w[10:8];
  assign bus.iss_pad     = iss_cluster_w[7:0];
  assign bus.iss_idx     = iss_idx_w;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_idx     = res_idx_q;
  assign bus.frame_done  = (state_q == S_DRAIN);
  assign bus.busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_gem_cluster_rom_sched.sv
// tb_gem_cluster_rom_sched
// Table-driven bench for gem_cluster_rom_sched (NCL=8). Each table row is one
// clock cycle: the inputs sampled at the edge that ends the cycle and the
// outputs expected during it. Expected rows are built from the frame's
// expected issue order, which depends on GEM_SCHED_SKIP_INVALID_EN.
module tb_gem_cluster_rom_sched;
  localparam int NCL  = 8;
  localparam int IDXB = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  gem_cluster_rom_sched_if #(.NCL(NCL), .IDXB(IDXB)) bus ();
  gem_cluster_rom_sched #(.NCL(NCL), .IDXB(IDXB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       fs;
    logic [7:0] vin;
    logic [7:0] seed;
    logic       ovc;
    logic       col;
    logic       busy;
    logic       iss;
    logic       ivpf;
    logic [2:0] iidx;
    logic [7:0] iseed;
    logic       rv;
    logic [2:0] ridx;
    logic       done;
    logic       ovf;
  } vec_t;

  vec_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [13:0] clw(input logic [7:0] seed, input int i);
    logic [2:0] ii;
    ii = 3'(i);
    return {seed[2:0] ^ ii, ~ii, seed + 8'(i * 17)};
  endfunction

  function automatic logic [NCL*14-1:0] pack_cl(input logic [7:0] seed);
    logic [NCL*14-1:0] r;
    for (int i = 0; i < NCL; i++) r[14*i +: 14] = clw(seed, i);
    return r;
  endfunction

  function automatic vec_t blank();
    vec_t t;
    t.fs = 1'b0; t.vin = 8'h00; t.seed = 8'hEE; t.ovc = 1'b0; t.col = 1'b0;
    t.busy = 1'b0; t.iss = 1'b0; t.ivpf = 1'b0; t.iidx = 3'd0; t.iseed = 8'h00;
    t.rv = 1'b0; t.ridx = 3'd0; t.done = 1'b0; t.ovf = 1'b0;
    return t;
  endfunction

  function automatic logic [39:0] exp_of(input vec_t v);
    logic [13:0] cl;
    cl = v.iss ? clw(v.iseed, int'(v.iidx)) : 14'd0;
    return {1'b0, v.busy, v.ivpf, v.iidx, cl, cl, v.rv, v.ridx, v.done, v.ovf};
  endfunction

  function automatic logic [39:0] actual();
    return {1'b0, bus.busy, bus.iss_vpf, bus.iss_idx, bus.iss_cluster,
            bus.iss_size, bus.iss_roll, bus.iss_pad,
            bus.res_valid, bus.res_idx, bus.frame_done, bus.overflow};
  endfunction

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_idle();
    q.push_back(blank());
  endtask

  // Turn the most recent row into the frame_start cycle of a new frame.
  task automatic start_on_last(input logic [7:0] vpf, input logic [7:0] seed);
    vec_t t;
    t = q[q.size()-1];
    t.fs = 1'b1; t.vin = vpf; t.seed = seed;
    q[q.size()-1] = t;
  endtask

  // Issue rows then the DRAIN row for a frame started on the previous row.
  task automatic add_frame(input logic [7:0] vpf, input logic [7:0] seed);
    int   lst[$];
    vec_t t;
    for (int s = 0; s < NCL; s++) begin
`ifdef GEM_SCHED_SKIP_INVALID_EN
      if (vpf[s]) lst.push_back(s);
`else
      lst.push_back(s);
`endif
    end
    if (lst.size() == 0) begin
      t = blank(); t.busy = 1'b1;
      q.push_back(t);
    end
    for (int j = 0; j < lst.size(); j++) begin
      t = blank();
      t.busy = 1'b1; t.iss = 1'b1; t.ivpf = vpf[lst[j]];
      t.iidx = 3'(lst[j]); t.iseed = seed;
      if (j > 0) begin t.rv = 1'b1; t.ridx = 3'(lst[j-1]); end
      q.push_back(t);
    end
    t = blank(); t.busy = 1'b1; t.done = 1'b1;
    if (lst.size() > 0) begin t.rv = 1'b1; t.ridx = 3'(lst[lst.size()-1]); end
    q.push_back(t);
  endtask

  // Mark an issue row as a collision: a new frame arrives and is dropped.
  task automatic collide(input int idx, input logic clr);
    vec_t t;
    t = q[idx];
    t.fs = 1'b1; t.vin = 8'h0F; t.seed = 8'h99; t.col = 1'b1; t.ovc = clr;
    q[idx] = t;
  endtask

  task automatic run_table(input string tag);
    vec_t t;
    logic o;
    o = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      t = q[i]; t.ovf = o; q[i] = t;
      if (t.col) o = 1'b1;
      else if (t.ovc) o = 1'b0;
    end
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clock);
      check($sformatf("%s[%0d]", tag, i), actual(), exp_of(q[i]));
      bus.frame_start = q[i].fs;
      bus.vpf_in      = q[i].vin;
      bus.clusters_in = pack_cl(q[i].seed);
      bus.ovf_clear   = q[i].ovc;
    end
    @(negedge clock);
    bus.frame_start = 1'b0;
    bus.vpf_in      = 8'h00;
    bus.ovf_clear   = 1'b0;
  endtask

  initial begin
    int idx;
    bus.frame_start = 1'b0;
    bus.clusters_in = '0;
    bus.vpf_in      = '0;
    bus.ovf_clear   = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_state", actual(), 40'd0);
    reset = 1'b0;

    // Sparse frame.
    push_idle(); push_idle();
    start_on_last(8'hA2, 8'h01); add_frame(8'hA2, 8'h01); push_idle();
    // Empty frame.
    push_idle();
    start_on_last(8'h00, 8'h02); add_frame(8'h00, 8'h02); push_idle();
    // Back-to-back: second frame accepted in the first frame's DRAIN cycle.
    push_idle();
    start_on_last(8'h81, 8'h03); add_frame(8'h81, 8'h03);
    start_on_last(8'h16, 8'h04); add_frame(8'h16, 8'h04); push_idle();
    // Collisions: drop alone, then drop together with ovf_clear, then a lone clear.
    push_idle();
    start_on_last(8'hF0, 8'h05);
    idx = q.size();
    add_frame(8'hF0, 8'h05);
    collide(idx, 1'b0);
    collide(idx + 2, 1'b1);
    push_idle();
    begin
      vec_t t;
      t = blank(); t.ovc = 1'b1;
      q.push_back(t);
    end
    push_idle(); push_idle();
    run_table("seq1");

    // Reset in the middle of ISSUE after two slots have been issued.
    @(negedge clock);
    bus.frame_start = 1'b1; bus.vpf_in = 8'hA2; bus.clusters_in = pack_cl(8'h06);
    @(negedge clock);
    bus.frame_start = 1'b0; bus.vpf_in = 8'h00; bus.clusters_in = pack_cl(8'hEE);
    @(negedge clock);
    @(negedge clock);
    check("pre_reset_busy", {39'd0, bus.busy}, 40'd1);
    reset = 1'b1;
    #1;
    check("reset_async", actual(), 40'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("no_done_in_reset[%0d]", i), actual(), 40'd0);
    end
    reset = 1'b0;

    q.delete();
    push_idle();
    start_on_last(8'hA2, 8'h07); add_frame(8'hA2, 8'h07); push_idle(); push_idle();
    run_table("seq2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
